// File: rtl/fft_2d_sched_if.sv
`default_nettype none
// ----------------------------------------------------------------------------
// fft_2d_sched_if : request/grant/completion bundle between requesters, the
// FFT engine control pins and fft_2d_sched.                 Revision: 1.0
// ----------------------------------------------------------------------------
interface fft_2d_sched_if #(
  parameter int N_REQ     = 2,
  parameter int TAG_DEPTH = 4,
  parameter int IDX_W     = (N_REQ > 1) ? $clog2(N_REQ) : 1,
  parameter int CNT_W     = $clog2(TAG_DEPTH + 1)
);
  logic [N_REQ-1:0] req;
  logic [N_REQ-1:0] grant;
  logic [IDX_W-1:0] grant_idx;
  logic             fft_next;
  logic             fft_next_out;
  logic [N_REQ-1:0] done;
  logic [IDX_W-1:0] done_idx;
  logic             busy;
  logic [CNT_W-1:0] inflight;
  logic             err_unexpected;

  // Requesters plus engine side.
  modport master (
    output req, fft_next_out,
    input  grant, grant_idx, fft_next, done, done_idx, busy, inflight, err_unexpected
  );

  // Scheduler side.
  modport slave (
    input  req, fft_next_out,
    output grant, grant_idx, fft_next, done, done_idx, busy, inflight, err_unexpected
  );
endinterface
`default_nettype wire

// File: rtl/fft_2d_sched.sv
`default_nettype none
// ----------------------------------------------------------------------------
// fft_2d_sched : round-robin time-sharing of one 2D FFT engine with start-gap
// enforcement and an in-order tag FIFO routing completions.  Revision: 1.0
// ----------------------------------------------------------------------------
module fft_2d_sched #(
  parameter int N_REQ     = 2,
  parameter int TAG_DEPTH = 4,
  parameter int ISSUE_GAP = 4,
  parameter int IDX_W     = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
  input  logic          clk,
  input  logic          reset,
  fft_2d_sched_if.slave bus
);
  localparam int CNT_W = $clog2(TAG_DEPTH + 1);
  localparam int PTR_W = $clog2(TAG_DEPTH);
  localparam int GAP_W = $clog2(ISSUE_GAP);

  localparam logic [0:0] ST_READY = 1'b0;
  localparam logic [0:0] ST_GAP   = 1'b1;

  logic [0:0]       state;
  logic [GAP_W-1:0] gap_cnt;
  logic [IDX_W-1:0] rr_ptr;
  logic [IDX_W-1:0] tag_mem [TAG_DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [CNT_W-1:0] count;
  logic [IDX_W-1:0] winner;
  logic [IDX_W-1:0] head;
  logic             issue;
  logic             pop;

  function automatic logic [IDX_W-1:0] wrap_idx(input logic [IDX_W-1:0] base, input int off);
    int s;
    s = int'(base) + off;
    if (s >= N_REQ) s = s - N_REQ;
    return s[IDX_W-1:0];
  endfunction

  // Scan from the farthest offset down so the nearest set bit at/after rr_ptr wins.
  always_comb begin
    winner = rr_ptr;
    for (int i = N_REQ - 1; i >= 0; i--) begin
      if (bus.req[wrap_idx(rr_ptr, i)]) winner = wrap_idx(rr_ptr, i);
    end
  end

  assign head  = tag_mem[rd_ptr];
  assign pop   = bus.fft_next_out && (count != '0);
  // A full FIFO may still accept an issue when the same edge pops a tag.
  assign issue = (state == ST_READY) && (|bus.req) &&
                 ((count != CNT_W'(TAG_DEPTH)) || bus.fft_next_out);

  always_ff @(posedge clk) begin
    if (issue) tag_mem[wr_ptr] <= winner;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state              <= ST_READY;
      gap_cnt            <= '0;
      rr_ptr             <= '0;
      wr_ptr             <= '0;
      rd_ptr             <= '0;
      count              <= '0;
      bus.grant          <= '0;
      bus.grant_idx      <= '0;
      bus.fft_next       <= 1'b0;
      bus.done           <= '0;
      bus.done_idx       <= '0;
      bus.err_unexpected <= 1'b0;
    end else begin
      bus.grant     <= issue ? (N_REQ'(1) << winner) : '0;
      bus.grant_idx <= issue ? winner : '0;
      bus.fft_next  <= issue;
      bus.done      <= pop ? (N_REQ'(1) << head) : '0;
      bus.done_idx  <= pop ? head : '0;

      if (issue) begin
        wr_ptr  <= wr_ptr + PTR_W'(1);
        rr_ptr  <= (winner == IDX_W'(N_REQ - 1)) ? '0 : winner + IDX_W'(1);
        state   <= ST_GAP;
        gap_cnt <= GAP_W'(ISSUE_GAP - 1);
      end else if (state == ST_GAP) begin
        gap_cnt <= gap_cnt - GAP_W'(1);
        if (gap_cnt == GAP_W'(1)) state <= ST_READY;
      end

      if (pop) rd_ptr <= rd_ptr + PTR_W'(1);
      if (bus.fft_next_out && (count == '0)) bus.err_unexpected <= 1'b1;

      case ({issue, pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  assign bus.inflight = count;
  assign bus.busy     = (count != '0) || (state == ST_GAP);
endmodule
`default_nettype wire

// File: tb/tb_fft_2d_sched.sv
`default_nettype none
// ----------------------------------------------------------------------------
// tb_fft_2d_sched : directed vector table plus randomized traffic against a
// queue-based reference model of the scheduler.             Revision: 1.0
// ----------------------------------------------------------------------------
module tb_fft_2d_sched;
  localparam int N_REQ     = 2;
  localparam int TAG_DEPTH = 4;
  localparam int ISSUE_GAP = 4;
  localparam int NV        = 27;

  logic clk   = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  fft_2d_sched_if #(.N_REQ(N_REQ), .TAG_DEPTH(TAG_DEPTH)) bus ();

  fft_2d_sched #(.N_REQ(N_REQ), .TAG_DEPTH(TAG_DEPTH), .ISSUE_GAP(ISSUE_GAP)) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  int checks   = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s at %0t: got %0h, expected %0h", name, $time, act, exp);
    end
  endtask

  // Reference model: tag queue, round-robin pointer and edge index of last issue.
  int               q[$];
  int               m_ptr  = 0;
  int               m_last = -1000;
  int               m_edge = 0;
  logic [N_REQ-1:0] m_grant = '0;
  logic [N_REQ-1:0] m_done  = '0;
  int               m_gidx = 0;
  int               m_didx = 0;
  logic             m_fn   = 1'b0;
  logic             m_err  = 1'b0;

  function automatic int pick(input logic [N_REQ-1:0] r, input int p);
    for (int i = 0; i < N_REQ; i++) if (r[(p + i) % N_REQ]) return (p + i) % N_REQ;
    return 0;
  endfunction

  function automatic logic m_busy();
    return (q.size() != 0) || (m_edge < m_last + ISSUE_GAP - 1);
  endfunction

  task automatic model_edge();
    logic [N_REQ-1:0] r;
    logic             f;
    int               sz;
    int               w;
    r = bus.req;
    f = bus.fft_next_out;
    m_edge++;
    m_grant = '0;
    m_done  = '0;
    m_fn    = 1'b0;
    if (reset) begin
      q.delete();
      m_ptr  = 0;
      m_last = -1000;
      m_err  = 1'b0;
      return;
    end
    sz = q.size();
    if (f && sz == 0) m_err = 1'b1;
    if (f && sz > 0) begin
      m_didx = q.pop_front();
      m_done[m_didx] = 1'b1;
    end
    if ((m_edge >= m_last + ISSUE_GAP) && (r != '0) && (sz < TAG_DEPTH || f)) begin
      w = pick(r, m_ptr);
      m_grant[w] = 1'b1;
      m_gidx = w;
      m_fn   = 1'b1;
      q.push_back(w);
      m_ptr  = (w + 1) % N_REQ;
      m_last = m_edge;
    end
  endtask

  task automatic step(input logic rst_v, input logic [N_REQ-1:0] r, input logic f);
    @(negedge clk);
    reset            = rst_v;
    bus.req          = r;
    bus.fft_next_out = f;
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic chk_model();
    chk("m_grant", bus.grant, m_grant);
    chk("m_fft_next", bus.fft_next, m_fn);
    chk("m_done", bus.done, m_done);
    if (m_grant != '0) chk("m_grant_idx", bus.grant_idx, m_gidx);
    if (m_done != '0) chk("m_done_idx", bus.done_idx, m_didx);
    chk("m_inflight", bus.inflight, q.size());
    chk("m_busy", bus.busy, m_busy());
    chk("m_err", bus.err_unexpected, m_err);
  endtask

  typedef struct {
    logic [1:0] req;
    logic       fno;
    logic [1:0] grant;
    int         gidx;
    logic [1:0] done;
    int         didx;
    int         infl;
    logic       busy;
    logic       err;
  } vec_t;

  vec_t tbl[NV];

  function automatic vec_t mk(input logic [1:0] req, input logic fno, input logic [1:0] grant,
                              input int gidx, input logic [1:0] done, input int didx,
                              input int infl, input logic busy, input logic err);
    vec_t v;
    v.req = req; v.fno = fno; v.grant = grant; v.gidx = gidx; v.done = done;
    v.didx = didx; v.infl = infl; v.busy = busy; v.err = err;
    return v;
  endfunction

  logic [N_REQ-1:0] rq;
  logic             rf;
  logic             rr;

  initial begin
    bus.req          = '0;
    bus.fft_next_out = 1'b0;

    // Both requesters held: grants 4 apart until the FIFO fills, then a pop lets one through.
    tbl[0] = mk(2'b11, 0, 2'b01, 0, 2'b00, 0, 1, 1, 0);
    for (int i = 1; i <= 3; i++) tbl[i] = mk(2'b11, 0, 2'b00, 0, 2'b00, 0, 1, 1, 0);
    tbl[4] = mk(2'b11, 0, 2'b10, 1, 2'b00, 0, 2, 1, 0);
    for (int i = 5; i <= 7; i++) tbl[i] = mk(2'b11, 0, 2'b00, 0, 2'b00, 0, 2, 1, 0);
    tbl[8] = mk(2'b11, 0, 2'b01, 0, 2'b00, 0, 3, 1, 0);
    for (int i = 9; i <= 11; i++) tbl[i] = mk(2'b11, 0, 2'b00, 0, 2'b00, 0, 3, 1, 0);
    tbl[12] = mk(2'b11, 0, 2'b10, 1, 2'b00, 0, 4, 1, 0);
    for (int i = 13; i <= 17; i++) tbl[i] = mk(2'b11, 0, 2'b00, 0, 2'b00, 0, 4, 1, 0);
    tbl[18] = mk(2'b11, 1, 2'b01, 0, 2'b01, 0, 4, 1, 0);
    tbl[19] = mk(2'b00, 1, 2'b00, 0, 2'b10, 1, 3, 1, 0);
    tbl[20] = mk(2'b00, 0, 2'b00, 0, 2'b00, 0, 3, 1, 0);
    tbl[21] = mk(2'b00, 1, 2'b00, 0, 2'b01, 0, 2, 1, 0);
    tbl[22] = mk(2'b00, 1, 2'b00, 0, 2'b10, 1, 1, 1, 0);
    tbl[23] = mk(2'b00, 1, 2'b00, 0, 2'b01, 0, 0, 0, 0);
    tbl[24] = mk(2'b00, 1, 2'b00, 0, 2'b00, 0, 0, 0, 1);
    tbl[25] = mk(2'b10, 0, 2'b10, 1, 2'b00, 0, 1, 1, 1);
    tbl[26] = mk(2'b00, 0, 2'b00, 0, 2'b00, 0, 1, 1, 1);

    for (int i = 0; i < 3; i++) begin
      step(1'b1, 2'b11, 1'b0);
      chk("rst_grant", bus.grant, 0);
      chk("rst_fft_next", bus.fft_next, 0);
      chk("rst_done", bus.done, 0);
      chk("rst_busy", bus.busy, 0);
    end

    for (int i = 0; i < NV; i++) begin
      step(1'b0, tbl[i].req, tbl[i].fno);
      chk($sformatf("v%0d_grant", i), bus.grant, tbl[i].grant);
      chk($sformatf("v%0d_fft_next", i), bus.fft_next, |tbl[i].grant);
      if (tbl[i].grant != '0) chk($sformatf("v%0d_grant_idx", i), bus.grant_idx, tbl[i].gidx);
      chk($sformatf("v%0d_done", i), bus.done, tbl[i].done);
      if (tbl[i].done != '0) chk($sformatf("v%0d_done_idx", i), bus.done_idx, tbl[i].didx);
      chk($sformatf("v%0d_inflight", i), bus.inflight, tbl[i].infl);
      chk($sformatf("v%0d_busy", i), bus.busy, tbl[i].busy);
      chk($sformatf("v%0d_err", i), bus.err_unexpected, tbl[i].err);
      chk_model();
    end

    // Reset in mid-gap with blocks in flight, then an immediate grant from pointer 0.
    step(1'b1, 2'b00, 1'b0);
    for (int i = 0; i < 9; i++) step(1'b0, 2'b11, 1'b0);
    chk("mid_inflight", bus.inflight, 3);
    chk("mid_grant", bus.grant, 2'b01);
    step(1'b0, 2'b11, 1'b0);
    chk("mid_gap_busy", bus.busy, 1);
    step(1'b1, 2'b11, 1'b0);
    chk("rst2_inflight", bus.inflight, 0);
    chk("rst2_busy", bus.busy, 0);
    chk("rst2_err", bus.err_unexpected, 0);
    chk("rst2_grant", bus.grant, 0);
    step(1'b0, 2'b11, 1'b0);
    chk("post_rst_grant", bus.grant, 2'b01);
    chk("post_rst_fft_next", bus.fft_next, 1);
    chk_model();

    // Randomized traffic: requesters drop req after their grant, engine completes at random.
    rq = '0;
    for (int c = 0; c < 3000; c++) begin
      for (int k = 0; k < N_REQ; k++) begin
        if (rq[k] && m_grant[k]) rq[k] = ($urandom_range(7) == 0);
        else if (!rq[k]) rq[k] = ($urandom_range(3) == 0);
        else if ($urandom_range(39) == 0) rq[k] = 1'b0;
      end
      rf = (q.size() > 0) ? ($urandom_range(2) == 0) : ($urandom_range(59) == 0);
      rr = ($urandom_range(399) == 0);
      step(rr, rq, rf);
      chk_model();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
`default_nettype wire
